// File: rtl/tx_dma_pkg.sv
// Shared TX DMA definitions: TLP fmt/type codes, TRN remainder codes,
// read-request FSM encoding and the MRRS decode.
package tx_dma_pkg;

   // {fmt[1:0], type[4:0]}
   localparam logic [6:0] MRD32        = 7'b00_00000;
   localparam logic [6:0] MRD64        = 7'b01_00000;
   localparam logic [6:0] CPL_MEM_RD64 = 7'b10_01010;

   localparam logic [7:0] TREM_BOTH  = 8'h00;
   localparam logic [7:0] TREM_UPPER = 8'h0F;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_HDR  = 3'd2,
      ST_ADDR = 3'd3,
      ST_ACK  = 3'd4
   } rd_req_state_e;

   // Reserved codes 6 and 7 decode as the largest size.
   function automatic logic [12:0] mrrs_to_bytes(input logic [2:0] code);
      logic [12:0] bytes;
      bytes = (code > 3'd5) ? 13'h1000 : (13'd128 << code);
      return bytes;
   endfunction

endpackage

// File: rtl/rd_req_tag_tracker.sv
// Tag allocator and outstanding-read counter for the TX read requester.
module rd_req_tag_tracker
   import tx_dma_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic       trn_clk,
   input  logic       reset,
   input  logic       issue,
   input  logic       cpl_done,
   output logic [4:0] tag,
   output logic [5:0] outstanding,
   output logic       can_issue
);

   localparam logic [5:0] MAX_CNT = 6'(MAX_OUTSTANDING);

   logic inc;
   logic dec;

   // A completion with nothing outstanding is dropped rather than underflowing.
   assign inc       = issue;
   assign dec       = cpl_done && (outstanding != 6'd0);
   assign can_issue = (outstanding < MAX_CNT);

   always_ff @(posedge trn_clk) begin
      if (reset) begin
         tag         <= 5'd0;
         outstanding <= 6'd0;
      end else begin
         if (issue)
            tag <= tag + 5'd1;
         if (inc && !dec)
            outstanding <= outstanding + 6'd1;
         else if (!inc && dec)
            outstanding <= outstanding - 6'd1;
      end
   end

endmodule

// File: rtl/tx_rd_req_tlp_gen.sv
// Host-to-card read requester: splits a chunk into Memory Read TLPs on TRN.
// Optional RD_REQ_3DW_EN emits 3DW headers for addresses below 4 GB.
module tx_rd_req_tlp_gen
   import tx_dma_pkg::*;
#(
   parameter int          CHUNK_BYTES     = 512,
   parameter int          MAX_OUTSTANDING = 8,
   parameter logic [15:0] REQ_ID_DEFAULT  = 16'h0100
) (
   input  logic        trn_clk,
   input  logic        reset,
   input  logic        read_chunk,
   input  logic [63:0] huge_page_addr_read_from,
   output logic        read_chunk_ack,
   input  logic        cpl_done,
   input  logic [15:0] cfg_completer_id,
   input  logic [15:0] cfg_dcommand,
   input  logic [5:0]  trn_tbuf_av,
   input  logic        trn_tdst_rdy_n,
   output logic [63:0] trn_td,
   output logic [7:0]  trn_trem_n,
   output logic        trn_tsof_n,
   output logic        trn_teof_n,
   output logic        trn_tsrc_rdy_n,
   output logic        trn_tsrc_dsc_n,
   output logic [5:0]  outstanding,
   output logic [2:0]  state_dbg
);

   rd_req_state_e state;
   logic [63:0]   addr_q;
   logic [12:0]   req_bytes_q;
   logic [5:0]    count_q;
   logic [12:0]   req_bytes_w;
   logic [5:0]    req_cnt_w;
   logic [4:0]    tag;
   logic          can_issue;
   logic          xfer;
   logic          issue;
   logic          use_3dw;
   logic [15:0]   req_id;
   logic [6:0]    hdr_type;
   logic [31:0]   dw0;
   logic [31:0]   dw1;
   logic [63:0]   beat2;
   logic [7:0]    rem2;
   logic          unused_bits;

   assign unused_bits    = ^{cfg_dcommand[15], cfg_dcommand[11:0], trn_tbuf_av[5:2], trn_tbuf_av[0]};
   assign trn_tsrc_dsc_n = 1'b1;
   assign state_dbg      = state;
   assign xfer           = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
   assign issue          = (state == ST_ADDR) && xfer;

   rd_req_tag_tracker #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_tracker (
      .trn_clk     (trn_clk),
      .reset       (reset),
      .issue       (issue),
      .cpl_done    (cpl_done),
      .tag         (tag),
      .outstanding (outstanding),
      .can_issue   (can_issue)
   );

   // Both sizes are powers of two, so the request count is a single shift.
   always_comb begin
      req_bytes_w = mrrs_to_bytes(cfg_dcommand[14:12]);
      if (req_bytes_w > 13'(CHUNK_BYTES))
         req_bytes_w = 13'(CHUNK_BYTES);
      req_cnt_w = 6'd1;
      for (int i = 7; i <= 12; i++)
         if (req_bytes_w[i])
            req_cnt_w = 6'(CHUNK_BYTES >> i);
   end

`ifdef RD_REQ_3DW_EN
   assign use_3dw = (addr_q[63:32] == 32'h0);
`else
   assign use_3dw = 1'b0;
`endif

   assign req_id   = (cfg_completer_id != 16'h0) ? cfg_completer_id : REQ_ID_DEFAULT;
   assign hdr_type = use_3dw ? MRD32 : MRD64;
   // A 4096-byte request has length 1024 DW, which truncates to 10'd0.
   assign dw0      = {1'b0, hdr_type, 8'h00, 6'b0, req_bytes_q[11:2]};
   assign dw1      = {req_id, 3'b0, tag, 4'hF, 4'hF};
   assign beat2    = use_3dw ? {addr_q[31:2], 2'b00, 32'h0} : {addr_q[63:32], addr_q[31:2], 2'b00};
   assign rem2     = use_3dw ? TREM_UPPER : TREM_BOTH;

   always_ff @(posedge trn_clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         trn_tsrc_rdy_n <= 1'b1;
         trn_tsof_n     <= 1'b1;
         trn_teof_n     <= 1'b1;
         trn_td         <= 64'h0;
         trn_trem_n     <= TREM_BOTH;
         read_chunk_ack <= 1'b0;
         addr_q         <= 64'h0;
         req_bytes_q    <= 13'h0;
         count_q        <= 6'h0;
      end else begin
         read_chunk_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (read_chunk && !read_chunk_ack) begin
                  addr_q      <= huge_page_addr_read_from;
                  req_bytes_q <= req_bytes_w;
                  count_q     <= req_cnt_w;
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (can_issue && trn_tbuf_av[1]) begin
                  trn_td         <= {dw0, dw1};
                  trn_trem_n     <= TREM_BOTH;
                  trn_tsof_n     <= 1'b0;
                  trn_teof_n     <= 1'b1;
                  trn_tsrc_rdy_n <= 1'b0;
                  state          <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (xfer) begin
                  trn_td     <= beat2;
                  trn_trem_n <= rem2;
                  trn_tsof_n <= 1'b1;
                  trn_teof_n <= 1'b0;
                  state      <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (xfer) begin
                  trn_tsrc_rdy_n <= 1'b1;
                  trn_teof_n     <= 1'b1;
                  addr_q         <= addr_q + 64'(req_bytes_q);
                  count_q        <= count_q - 6'd1;
                  if (count_q == 6'd1) begin
                     read_chunk_ack <= 1'b1;
                     state          <= ST_ACK;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_rd_req_tlp_gen.sv
// Directed bench for tx_rd_req_tlp_gen (MAX_OUTSTANDING=2, CHUNK_BYTES=512).
module tb_tx_rd_req_tlp_gen;
   import tx_dma_pkg::*;

   logic        trn_clk = 1'b0;
   logic        reset = 1'b1;
   logic        read_chunk = 1'b0;
   logic [63:0] huge_page_addr_read_from = 64'h0;
   logic        read_chunk_ack;
   logic        cpl_done = 1'b0;
   logic [15:0] cfg_completer_id = 16'h0;
   logic [15:0] cfg_dcommand = 16'h0;
   logic [5:0]  trn_tbuf_av = 6'b000010;
   logic        trn_tdst_rdy_n = 1'b0;
   logic [63:0] trn_td;
   logic [7:0]  trn_trem_n;
   logic        trn_tsof_n;
   logic        trn_teof_n;
   logic        trn_tsrc_rdy_n;
   logic        trn_tsrc_dsc_n;
   logic [5:0]  outstanding;
   logic [2:0]  state_dbg;

   int checks = 0;
   int failures = 0;
   logic [4:0] exp_q[$];

   always #5 trn_clk = ~trn_clk;

   tx_rd_req_tlp_gen #(
      .CHUNK_BYTES     (512),
      .MAX_OUTSTANDING (2),
      .REQ_ID_DEFAULT  (16'h0100)
   ) u_dut (
      .trn_clk                  (trn_clk),
      .reset                    (reset),
      .read_chunk               (read_chunk),
      .huge_page_addr_read_from (huge_page_addr_read_from),
      .read_chunk_ack           (read_chunk_ack),
      .cpl_done                 (cpl_done),
      .cfg_completer_id         (cfg_completer_id),
      .cfg_dcommand             (cfg_dcommand),
      .trn_tbuf_av              (trn_tbuf_av),
      .trn_tdst_rdy_n           (trn_tdst_rdy_n),
      .trn_td                   (trn_td),
      .trn_trem_n               (trn_trem_n),
      .trn_tsof_n               (trn_tsof_n),
      .trn_teof_n               (trn_teof_n),
      .trn_tsrc_rdy_n           (trn_tsrc_rdy_n),
      .trn_tsrc_dsc_n           (trn_tsrc_dsc_n),
      .outstanding              (outstanding),
      .state_dbg                (state_dbg)
   );

   // ---------------- clock / reset and driver tasks ----------------
   task automatic tick();
      @(posedge trn_clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      read_chunk     = 1'b0;
      cpl_done       = 1'b0;
      trn_tdst_rdy_n = 1'b0;
      trn_tbuf_av    = 6'b000010;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic start_chunk(input logic [63:0] addr, input logic [2:0] code, input logic [15:0] id);
      huge_page_addr_read_from = addr;
      cfg_dcommand             = {1'b0, code, 12'h000};
      cfg_completer_id         = id;
      read_chunk               = 1'b1;
   endtask

   task automatic pulse_cpl();
      cpl_done = 1'b1;
      tick();
      cpl_done = 1'b0;
   endtask

   task automatic wait_sof(output logic to);
      to = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (!trn_tsrc_rdy_n && !trn_tsof_n) begin
            to = 1'b0;
            break;
         end
         tick();
      end
   endtask

   // Captures one two-beat TLP with the core ready every cycle.
   task automatic get_tlp(output logic [63:0] b1, output logic [63:0] b2,
                          output logic [7:0] rem2, output logic eof2, output logic to);
      b1 = 64'h0; b2 = 64'h0; rem2 = 8'h0; eof2 = 1'b1;
      wait_sof(to);
      if (!to) begin
         b1 = trn_td;
         tick();
         b2   = trn_td;
         rem2 = trn_trem_n;
         eof2 = trn_teof_n;
         tick();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++; if ({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n} !== 4'hF) begin failures++; $display("FAIL reset_ctrl: got %b expected 1111", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n}); end
      checks++; if (trn_td !== 64'h0) begin failures++; $display("FAIL reset_td: got %h expected 0", trn_td); end
      checks++; if (trn_trem_n !== 8'h00) begin failures++; $display("FAIL reset_trem: got %h expected 00", trn_trem_n); end
      checks++; if (read_chunk_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", read_chunk_ack); end
      checks++; if (outstanding !== 6'd0) begin failures++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
      checks++; if (state_dbg !== 3'(ST_IDLE)) begin failures++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
   endtask

   task automatic test_single_512();
      logic [63:0] b1, b2; logic [7:0] rem; logic eof, to; int lat;
      do_reset();
      start_chunk(64'h0000_0001_2345_6000, 3'd2, 16'h0000);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         tick(); lat++;
         if (!trn_tsof_n) break;
      end
      checks++; if (lat !== 2) begin failures++; $display("FAIL single_latency: got %0d expected 2", lat); end
      get_tlp(b1, b2, rem, eof, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL single_timeout: got %b expected 0", to); end
      checks++; if (b1 !== 64'h2000_0080_0100_00FF) begin failures++; $display("FAIL single_beat1: got %h expected 2000008001 0000ff", b1); end
      checks++; if (b2 !== 64'h0000_0001_2345_6000) begin failures++; $display("FAIL single_beat2: got %h expected 0000000123456000", b2); end
      checks++; if ({rem, eof} !== {8'h00, 1'b0}) begin failures++; $display("FAIL single_rem_eof: got %h/%b expected 00/0", rem, eof); end
      checks++; if ({read_chunk_ack, outstanding} !== {1'b1, 6'd1}) begin failures++; $display("FAIL single_ack_out: got %b/%0d expected 1/1", read_chunk_ack, outstanding); end
      read_chunk = 1'b0;
      tick();
      checks++; if ({read_chunk_ack, state_dbg} !== {1'b0, 3'(ST_IDLE)}) begin failures++; $display("FAIL single_ack_drop: got %b/%0d expected 0/%0d", read_chunk_ack, state_dbg, ST_IDLE); end
      pulse_cpl();
      checks++; if (outstanding !== 6'd0) begin failures++; $display("FAIL single_cpl: got %0d expected 0", outstanding); end
   endtask

   task automatic test_mrrs0();
      logic [63:0] b1, b2, base; logic [7:0] rem; logic eof, to;
      do_reset();
      base = 64'hFFFF_FFFF_FFFF_FE00;
      start_chunk(base, 3'd0, 16'hBEEF);
      for (int i = 0; i < 4; i++) begin
         get_tlp(b1, b2, rem, eof, to);
         if (i == 0) cfg_dcommand = 16'h2000;  // must not affect the chunk in progress
         checks++; if (to !== 1'b0) begin failures++; $display("FAIL mrrs0_timeout[%0d]: got %b expected 0", i, to); end
         checks++; if (b1 !== {32'h2000_0020, 16'hBEEF, 3'b000, 5'(i), 8'hFF}) begin failures++; $display("FAIL mrrs0_beat1[%0d]: got %h expected %h", i, b1, {32'h2000_0020, 16'hBEEF, 3'b000, 5'(i), 8'hFF}); end
         checks++; if (b2 !== base + 64'(i * 128)) begin failures++; $display("FAIL mrrs0_addr[%0d]: got %h expected %h", i, b2, base + 64'(i * 128)); end
         checks++; if (read_chunk_ack !== (i == 3)) begin failures++; $display("FAIL mrrs0_ack[%0d]: got %b expected %b", i, read_chunk_ack, (i == 3)); end
         if (i == 3) read_chunk = 1'b0;
         pulse_cpl();
      end
      checks++; if (state_dbg !== 3'(ST_IDLE)) begin failures++; $display("FAIL mrrs0_end_state: got %0d expected %0d", state_dbg, ST_IDLE); end
   endtask

   task automatic test_hold();
      logic [63:0] held; logic to, sof_seen;
      do_reset();
      trn_tdst_rdy_n = 1'b1;
      start_chunk(64'h0000_0007_0000_0200, 3'd2, 16'h1234);
      wait_sof(to);
      held = trn_td;
      checks++; if ({to, held} !== {1'b0, 64'h2000_0080_1234_00FF}) begin failures++; $display("FAIL hold_beat1: got %b/%h expected 0/20000080123400ff", to, held); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if ({trn_td, trn_tsof_n, trn_tsrc_rdy_n} !== {held, 2'b00}) begin failures++; $display("FAIL hold_stable[%0d]: got %h/%b/%b expected %h/0/0", i, trn_td, trn_tsof_n, trn_tsrc_rdy_n, held); end
      end
      trn_tdst_rdy_n = 1'b0;
      tick();
      checks++; if ({trn_tsof_n, trn_teof_n, trn_td} !== {1'b1, 1'b0, 64'h0000_0007_0000_0200}) begin failures++; $display("FAIL hold_beat2: got %b/%b/%h expected 1/0/0000000700000200", trn_tsof_n, trn_teof_n, trn_td); end
      tick();
      checks++; if (read_chunk_ack !== 1'b1) begin failures++; $display("FAIL hold_ack: got %b expected 1", read_chunk_ack); end
      read_chunk = 1'b0;
      pulse_cpl();
      sof_seen = 1'b0;
      repeat (3) begin tick(); if (!trn_tsof_n) sof_seen = 1'b1; end
      checks++; if (sof_seen !== 1'b0) begin failures++; $display("FAIL hold_dup: got %b expected 0", sof_seen); end
   endtask

   task automatic test_throttle();
      logic [63:0] b1, b2, base; logic [7:0] rem; logic eof, to, sof_seen;
      do_reset();
      base = 64'h0000_0000_0040_0000;
      start_chunk(base, 3'd0, 16'h0000);
      get_tlp(b1, b2, rem, eof, to);
      checks++; if ({to, b1, outstanding} !== {1'b0, 64'h2000_0020_0100_00FF, 6'd1}) begin failures++; $display("FAIL thr_tlp0: got %b/%h/%0d expected 0/20000020010000ff/1", to, b1, outstanding); end
      get_tlp(b1, b2, rem, eof, to);
      checks++; if ({to, b1, outstanding} !== {1'b0, 64'h2000_0020_0100_01FF, 6'd2}) begin failures++; $display("FAIL thr_tlp1: got %b/%h/%0d expected 0/20000020010001ff/2", to, b1, outstanding); end
      sof_seen = 1'b0;
      repeat (4) begin tick(); if (!trn_tsrc_rdy_n) sof_seen = 1'b1; end
      checks++; if ({sof_seen, state_dbg} !== {1'b0, 3'(ST_WAIT)}) begin failures++; $display("FAIL thr_stall: got %b/%0d expected 0/%0d", sof_seen, state_dbg, ST_WAIT); end
      trn_tbuf_av = 6'b000000;
      pulse_cpl();
      checks++; if (outstanding !== 6'd1) begin failures++; $display("FAIL thr_cpl1: got %0d expected 1", outstanding); end
      repeat (3) begin tick(); if (!trn_tsrc_rdy_n) sof_seen = 1'b1; end
      checks++; if (sof_seen !== 1'b0) begin failures++; $display("FAIL thr_tbuf_gate: got %b expected 0", sof_seen); end
      trn_tbuf_av = 6'b000010;
      get_tlp(b1, b2, rem, eof, to);
      checks++; if ({to, b1, b2, outstanding} !== {1'b0, 64'h2000_0020_0100_02FF, base + 64'h100, 6'd2}) begin failures++; $display("FAIL thr_tlp2: got %b/%h/%h/%0d", to, b1, b2, outstanding); end
      repeat (3) begin tick(); if (!trn_tsrc_rdy_n) sof_seen = 1'b1; end
      checks++; if (sof_seen !== 1'b0) begin failures++; $display("FAIL thr_one_more: got %b expected 0", sof_seen); end
      pulse_cpl();
      wait_sof(to);
      b1 = trn_td;
      tick();
      b2 = trn_td;
      cpl_done = 1'b1;  // completion lands on the same edge as the issue
      tick();
      cpl_done = 1'b0;
      checks++; if ({to, b1, b2} !== {1'b0, 64'h2000_0020_0100_03FF, base + 64'h180}) begin failures++; $display("FAIL thr_tlp3: got %b/%h/%h", to, b1, b2); end
      checks++; if ({outstanding, read_chunk_ack} !== {6'd1, 1'b1}) begin failures++; $display("FAIL thr_same_cycle: got %0d/%b expected 1/1", outstanding, read_chunk_ack); end
      read_chunk = 1'b0;
      pulse_cpl();
      pulse_cpl();
      checks++; if (outstanding !== 6'd0) begin failures++; $display("FAIL thr_underflow: got %0d expected 0", outstanding); end
   endtask

   task automatic test_tag_wrap_reset();
      logic [63:0] b1, b2; logic [7:0] rem; logic eof, to; logic [4:0] exp_tag; int n;
      do_reset();
      exp_q.delete();
      for (int t = 0; t < 33; t++) exp_q.push_back(5'(t));
      for (int c = 0; c < 9; c++) begin
         start_chunk(64'h0000_0002_0000_0000 + 64'(c * 512), 3'd0, 16'h0000);
         n = (c == 8) ? 1 : 4;
         for (int k = 0; k < n; k++) begin
            get_tlp(b1, b2, rem, eof, to);
            exp_tag = exp_q.pop_front();
            checks++; if ({to, b1[12:8]} !== {1'b0, exp_tag}) begin failures++; $display("FAIL wrap_tag[%0d.%0d]: got %b/%0d expected 0/%0d", c, k, to, b1[12:8], exp_tag); end
            if (c < 8) begin
               if (k == 3) read_chunk = 1'b0;
               pulse_cpl();
            end
         end
      end
      wait_sof(to);
      checks++; if ({to, trn_td[12:8]} !== {1'b0, 5'd1}) begin failures++; $display("FAIL wrap_tag34: got %b/%0d expected 0/1", to, trn_td[12:8]); end
      tick();
      checks++; if (trn_teof_n !== 1'b0) begin failures++; $display("FAIL wrap_in_beat2: got %b expected 0", trn_teof_n); end
      reset      = 1'b1;
      read_chunk = 1'b0;
      tick();
      reset = 1'b0;
      checks++; if ({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n, trn_td, trn_trem_n} !== {4'hF, 64'h0, 8'h00}) begin failures++; $display("FAIL abort_outputs: got %b%b%b%b/%h/%h", trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n, trn_td, trn_trem_n); end
      checks++; if ({read_chunk_ack, outstanding, state_dbg} !== {1'b0, 6'd0, 3'(ST_IDLE)}) begin failures++; $display("FAIL abort_state: got %b/%0d/%0d expected 0/0/%0d", read_chunk_ack, outstanding, state_dbg, ST_IDLE); end
      start_chunk(64'h0000_0003_0000_0000, 3'd2, 16'h0000);
      get_tlp(b1, b2, rem, eof, to);
      checks++; if ({to, b1} !== {1'b0, 64'h2000_0080_0100_00FF}) begin failures++; $display("FAIL abort_tag0: got %b/%h expected 0/20000080010000ff", to, b1); end
      read_chunk = 1'b0;
      pulse_cpl();
   endtask

   task automatic test_low_addr();
      logic [63:0] b1, b2, exp_b1, exp_b2; logic [7:0] rem, exp_rem; logic eof, to;
`ifdef RD_REQ_3DW_EN
      exp_b1  = 64'h0000_0080_0100_00FF;
      exp_b2  = 64'h8000_0000_0000_0000;
      exp_rem = 8'h0F;
`else
      exp_b1  = 64'h2000_0080_0100_00FF;
      exp_b2  = 64'h0000_0000_8000_0000;
      exp_rem = 8'h00;
`endif
      do_reset();
      start_chunk(64'h0000_0000_8000_0000, 3'd7, 16'h0000);  // reserved code clamps to the chunk size
      get_tlp(b1, b2, rem, eof, to);
      checks++; if ({to, b1} !== {1'b0, exp_b1}) begin failures++; $display("FAIL low_beat1: got %b/%h expected 0/%h", to, b1, exp_b1); end
      checks++; if ({b2, rem, eof} !== {exp_b2, exp_rem, 1'b0}) begin failures++; $display("FAIL low_beat2: got %h/%h/%b expected %h/%h/0", b2, rem, eof, exp_b2, exp_rem); end
      checks++; if (read_chunk_ack !== 1'b1) begin failures++; $display("FAIL low_ack: got %b expected 1", read_chunk_ack); end
      read_chunk = 1'b0;
      pulse_cpl();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_512();
      test_mrrs0();
      test_hold();
      test_throttle();
      test_tag_wrap_reset();
      test_low_addr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
